// File: rtl/v_mem_access_mb_if.sv
// Bus bundle for v_mem_access_mb: the vector-side request/response and the RAM-side beat port.
// The slave modport is the mover itself. The master modport is its environment (requester plus RAM).
interface v_mem_access_mb_if #(
  parameter int VMEM_DW = 256,
  parameter int VMEM_AW = 32,
  parameter int VRAM_DW = 64,
  parameter int VRAM_AW = 32
);
  logic                   vmem_ren_i;
  logic                   vmem_wen_i;
  logic [VMEM_AW-1:0]     vmem_addr_i;
  logic [VMEM_DW-1:0]     vmem_din_i;
  logic [VMEM_DW/8-1:0]   vmem_bmask_i;
  logic [VMEM_DW-1:0]     vmem_dout_o;
  logic                   vmem_busy_o;
  logic                   vmem_done_o;
  logic                   vram_ren_o;
  logic                   vram_wen_o;
  logic [VRAM_AW-1:0]     vram_addr_o;
  logic [VRAM_DW-1:0]     vram_mask_o;
  logic [VRAM_DW-1:0]     vram_din_o;
  logic [VRAM_DW-1:0]     vram_dout_i;

  modport slave (
    input  vmem_ren_i, vmem_wen_i, vmem_addr_i, vmem_din_i, vmem_bmask_i, vram_dout_i,
    output vmem_dout_o, vmem_busy_o, vmem_done_o,
           vram_ren_o, vram_wen_o, vram_addr_o, vram_mask_o, vram_din_o
  );

  modport master (
    output vmem_ren_i, vmem_wen_i, vmem_addr_i, vmem_din_i, vmem_bmask_i, vram_dout_i,
    input  vmem_dout_o, vmem_busy_o, vmem_done_o,
           vram_ren_o, vram_wen_o, vram_addr_o, vram_mask_o, vram_din_o
  );
endinterface

// File: rtl/v_mem_access_mb.sv
// Splits one wide vector load/store into BEATS consecutive narrow RAM beats.
// Load beats are reassembled into vmem_dout_o, which is updated only when a whole read completes.
module v_mem_access_mb #(
  parameter int VMEM_DW     = 256,
  parameter int VMEM_AW     = 32,
  parameter int VRAM_DW     = 64,
  parameter int VRAM_AW     = 32,
  parameter int VRAM_RD_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  v_mem_access_mb_if.slave  bus
);

  localparam int BEATS = VMEM_DW / VRAM_DW;
  localparam int BPB   = VRAM_DW / 8;
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(BEATS) + 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic [VMEM_AW-1:0]     base_q;
  logic [VMEM_DW-1:0]     din_q;
  logic [VMEM_DW/8-1:0]   bmask_q;
  logic                   ren_q, wen_q;
  logic [VRAM_AW-1:0]     vaddr_q;
  logic [VRAM_DW-1:0]     vmask_q, vdin_q;
  logic [VRAM_RD_LAT-1:0] vld_q;
  logic [IW-1:0]          idx_q [VRAM_RD_LAT];
  logic [VMEM_DW-1:0]     rdbuf_q, dout_q, rd_merged;

  logic                   accept, issue, is_wr, cap, cap_last;
  logic [IW-1:0]          issue_k;
  logic [VMEM_AW-1:0]     src_addr;
  logic [VMEM_DW-1:0]     src_din;
  logic [VMEM_DW/8-1:0]   src_bmask;
  logic [VRAM_AW-1:0]     beat_addr;
  logic [VRAM_DW-1:0]     beat_din, beat_mask;
  logic [BPB-1:0]         beat_bytes;

  assign cap      = vld_q[VRAM_RD_LAT-1];
  assign cap_last = cap && (idx_q[VRAM_RD_LAT-1] == IW'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Beat 0 is issued on the acceptance edge itself, so it is sourced from the live inputs.
  always_comb begin
    accept  = (state_q == IDLE || state_q == DONE) && (bus.vmem_ren_i || bus.vmem_wen_i);
    issue   = accept || ((state_q == WRITE || state_q == READ) && cnt_q != CW'(BEATS));
    is_wr   = accept ? bus.vmem_wen_i : (state_q == WRITE);
    issue_k = accept ? '0 : cnt_q[IW-1:0];
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = accept ? (bus.vmem_wen_i ? WRITE : READ) : IDLE;
      WRITE:      if (cnt_q == CW'(BEATS)) state_d = DONE;
      READ:       if (cnt_q == CW'(BEATS)) state_d = DRAIN;
      DRAIN:      if (cap_last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    src_addr   = accept ? bus.vmem_addr_i  : base_q;
    src_din    = accept ? bus.vmem_din_i   : din_q;
    src_bmask  = accept ? bus.vmem_bmask_i : bmask_q;
    beat_addr  = VRAM_AW'(src_addr) + VRAM_AW'(issue_k) * VRAM_AW'(BPB);
    beat_din   = src_din[issue_k*VRAM_DW +: VRAM_DW];
    beat_bytes = src_bmask[issue_k*BPB +: BPB];
    beat_mask  = '0;
    for (int unsigned i = 0; i < BPB; i++) beat_mask[i*8 +: 8] = {8{beat_bytes[i]}};
    rd_merged  = rdbuf_q;
    rd_merged[idx_q[VRAM_RD_LAT-1]*VRAM_DW +: VRAM_DW] = bus.vram_dout_i;

    bus.vmem_busy_o = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
    bus.vmem_done_o = (state_q == DONE);
    bus.vmem_dout_o = dout_q;
    bus.vram_ren_o  = ren_q;
    bus.vram_wen_o  = wen_q;
    bus.vram_addr_o = vaddr_q;
    bus.vram_mask_o = vmask_q;
    bus.vram_din_o  = vdin_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      base_q  <= '0;
      din_q   <= '0;
      bmask_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      vaddr_q <= '0;
      vmask_q <= '0;
      vdin_q  <= '0;
      vld_q   <= '0;
      rdbuf_q <= '0;
      dout_q  <= '0;
      for (int unsigned i = 0; i < VRAM_RD_LAT; i++) idx_q[i] <= '0;
    end else begin
      if (accept) begin
        base_q  <= bus.vmem_addr_i;
        din_q   <= bus.vmem_din_i;
        bmask_q <= bus.vmem_bmask_i;
      end
      cnt_q   <= accept ? CW'(1) : (issue ? cnt_q + 1'b1 : cnt_q);
      ren_q   <= issue && !is_wr;
      wen_q   <= issue && is_wr && (|beat_bytes);
      vmask_q <= (issue && is_wr) ? beat_mask : '0;
      if (issue)          vaddr_q <= beat_addr;
      if (issue && is_wr) vdin_q  <= beat_din;
      // The beat on the bus this cycle is index cnt_q-1; its data returns VRAM_RD_LAT cycles later.
      vld_q[0] <= ren_q;
      idx_q[0] <= IW'(cnt_q - 1'b1);
      for (int unsigned i = 1; i < VRAM_RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
      if (cap)      rdbuf_q <= rd_merged;
      if (cap_last) dout_q  <= rd_merged;
    end
  end

endmodule

// File: tb/tb_v_mem_access_mb.sv
// Directed bench for v_mem_access_mb with 256-bit vectors, 64-bit RAM beats and read latency 1.
// A behavioural RAM answers the beats; expected values are hand-computed constants.
module tb_v_mem_access_mb;

  typedef struct packed {
    bit              wr;
    logic [31:0]     addr;
    logic [255:0]    din;
    logic [31:0]     bmask;
    logic [3:0]      exp_wen;
    logic [3:0][31:0] exp_addr;
    logic [3:0][63:0] exp_mask;
    logic [255:0]    exp_dout;
    int              done_at;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  v_mem_access_mb_if #(.VMEM_DW(256), .VMEM_AW(32), .VRAM_DW(64), .VRAM_AW(32)) u_if ();

  v_mem_access_mb #(
    .VMEM_DW(256), .VMEM_AW(32), .VRAM_DW(64), .VRAM_AW(32), .VRAM_RD_LAT(1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  logic [63:0] mem [logic [31:0]];
  logic [63:0] ram_q = '0;
  assign u_if.vram_dout_i = ram_q;

  function automatic logic [63:0] ram_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (64'hDEADBEEF_00000000 | {32'h0, a});
  endfunction

  always @(posedge clk) begin
    if (u_if.vram_wen_o)
      mem[u_if.vram_addr_o] = (ram_rd(u_if.vram_addr_o) & ~u_if.vram_mask_o)
                              | (u_if.vram_din_o & u_if.vram_mask_o);
    if (u_if.vram_ren_o) ram_q <= ram_rd(u_if.vram_addr_o);
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [255:0] d, input logic [31:0] m);
    u_if.vmem_ren_i   = rd;
    u_if.vmem_wen_i   = wr;
    u_if.vmem_addr_i  = a;
    u_if.vmem_din_i   = d;
    u_if.vmem_bmask_i = m;
    @(posedge clk);
    #1;
    u_if.vmem_ren_i = 1'b0;
    u_if.vmem_wen_i = 1'b0;
  endtask

  function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [255:0] d,
                              input logic [31:0] m, input logic [3:0] wen,
                              input logic [127:0] addrs, input logic [255:0] mask,
                              input logic [255:0] dout, input int done_at);
    vec_t v;
    v.wr = wr; v.addr = a; v.din = d; v.bmask = m; v.exp_wen = wen;
    v.exp_addr = addrs; v.exp_mask = mask; v.exp_dout = dout; v.done_at = done_at;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input int id);
    drive(!v.wr, v.wr, v.addr, v.din, v.bmask);
    for (int n = 1; n <= v.done_at; n++) begin
      int k;
      @(negedge clk);
      k = n - 1;
      if (k < 4) begin
        chk($sformatf("v%0d.c%0d.ren", id, n), u_if.vram_ren_o, !v.wr);
        chk($sformatf("v%0d.c%0d.wen", id, n), u_if.vram_wen_o, v.wr && v.exp_wen[k]);
        chk($sformatf("v%0d.c%0d.addr", id, n), u_if.vram_addr_o, v.exp_addr[k]);
        chk($sformatf("v%0d.c%0d.mask", id, n), u_if.vram_mask_o, v.exp_mask[k]);
        if (v.wr) chk($sformatf("v%0d.c%0d.din", id, n), u_if.vram_din_o, v.din[k*64 +: 64]);
      end else begin
        chk($sformatf("v%0d.c%0d.strobes", id, n),
            {u_if.vram_ren_o, u_if.vram_wen_o, u_if.vram_mask_o}, '0);
      end
      chk($sformatf("v%0d.c%0d.busy", id, n), u_if.vmem_busy_o, n < v.done_at);
      chk($sformatf("v%0d.c%0d.done", id, n), u_if.vmem_done_o, n == v.done_at);
      if (n == v.done_at) chk($sformatf("v%0d.dout", id), u_if.vmem_dout_o, v.exp_dout);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, u_if.vmem_busy_o, '0);
    chk({tag, ".done"}, u_if.vmem_done_o, '0);
    chk({tag, ".ren"},  u_if.vram_ren_o,  '0);
    chk({tag, ".wen"},  u_if.vram_wen_o,  '0);
    chk({tag, ".mask"}, u_if.vram_mask_o, '0);
    chk({tag, ".addr"}, u_if.vram_addr_o, '0);
    chk({tag, ".din"},  u_if.vram_din_o,  '0);
    chk({tag, ".dout"}, u_if.vmem_dout_o, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] d0, d2, d3, w1234;
    vec_t vt [6];

    d0 = {64'hA3A3A3A3_00000003, 64'hA2A2A2A2_00000002, 64'hA1A1A1A1_00000001, 64'hA0A0A0A0_00000000};
    d2 = {64'hB3B3B3B3_00000003, 64'hB2B2B2B2_00000002, 64'hB1B1B1B1_00000001, 64'hB0B0B0B0_00000000};
    d3 = {64'hC3C3C3C3_00000003, 64'hC2C2C2C2_00000002, 64'hC1C1C1C1_00000001, 64'hC0C0C0C0_00000000};
    w1234 = {64'd4, 64'd3, 64'd2, 64'd1};

    mem[32'h200] = 64'd1;
    mem[32'h208] = 64'd2;
    mem[32'h210] = 64'd3;
    mem[32'h218] = 64'd4;

    vt[0] = mk(1'b1, 32'h100, d0, 32'hFFFFFFFF, 4'b1111,
               {32'h118, 32'h110, 32'h108, 32'h100}, '1, '0, 5);
    vt[1] = mk(1'b0, 32'h200, '0, '0, 4'b0000,
               {32'h218, 32'h210, 32'h208, 32'h200}, '0, w1234, 6);
    vt[2] = mk(1'b1, 32'h300, d2, 32'h0000FF00, 4'b0010,
               {32'h318, 32'h310, 32'h308, 32'h300},
               {64'h0, 64'h0, {64{1'b1}}, 64'h0}, w1234, 5);
    vt[3] = mk(1'b1, 32'hFFFFFFF0, d3, 32'hFFFFFFFF, 4'b1111,
               {32'h00000008, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFF0}, '1, w1234, 5);
    vt[4] = mk(1'b0, 32'h100, '0, '0, 4'b0000,
               {32'h118, 32'h110, 32'h108, 32'h100}, '0, d0, 6);
    vt[5] = mk(1'b0, 32'h300, '0, '0, 4'b0000,
               {32'h318, 32'h310, 32'h308, 32'h300}, '0,
               {64'hDEADBEEF_00000318, 64'hDEADBEEF_00000310,
                64'hB1B1B1B1_00000001, 64'hDEADBEEF_00000300}, 6);

    u_if.vmem_ren_i   = 1'b0;
    u_if.vmem_wen_i   = 1'b0;
    u_if.vmem_addr_i  = '0;
    u_if.vmem_din_i   = '0;
    u_if.vmem_bmask_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset.held");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset.after");

    for (int i = 0; i < 6; i++) run_txn(vt[i], i);

    // ren and wen together give a write; a request while busy is dropped
    drive(1'b1, 1'b1, 32'h400, d0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("both.c1.wen", u_if.vram_wen_o, 1'b1);
    chk("both.c1.ren", u_if.vram_ren_o, 1'b0);
    chk("both.c1.addr", u_if.vram_addr_o, 32'h400);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h500, '0, '0);
    @(negedge clk);
    chk("both.c3.addr", u_if.vram_addr_o, 32'h410);
    chk("both.c3.wen", u_if.vram_wen_o, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("both.c5.done", u_if.vmem_done_o, 1'b1);
    @(negedge clk);
    chk("drop.c6.busy", u_if.vmem_busy_o, 1'b0);
    chk("drop.c6.ren", u_if.vram_ren_o, 1'b0);
    @(negedge clk);
    chk("drop.c7.busy", u_if.vmem_busy_o, 1'b0);
    chk("drop.c7.done", u_if.vmem_done_o, 1'b0);

    // back-to-back: a load accepted in the DONE cycle of a store
    drive(1'b0, 1'b1, 32'h600, d3, 32'hFFFFFFFF);
    repeat (5) @(negedge clk);
    chk("b2b.wdone", u_if.vmem_done_o, 1'b1);
    drive(1'b1, 1'b0, 32'h200, '0, '0);
    @(negedge clk);
    chk("b2b.c1.ren", u_if.vram_ren_o, 1'b1);
    chk("b2b.c1.addr", u_if.vram_addr_o, 32'h200);
    chk("b2b.c1.busy", u_if.vmem_busy_o, 1'b1);
    repeat (5) @(negedge clk);
    chk("b2b.c6.done", u_if.vmem_done_o, 1'b1);
    chk("b2b.c6.busy", u_if.vmem_busy_o, 1'b0);
    chk("b2b.dout", u_if.vmem_dout_o, w1234);

    // reset during beat 2 of a load
    drive(1'b1, 1'b0, 32'h100, '0, '0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort.c3.ren", u_if.vram_ren_o, 1'b1);
    chk("abort.c3.addr", u_if.vram_addr_o, 32'h110);
    rst = 1'b1;
    #1;
    chk_all_zero("abort.rst");
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk($sformatf("abort.q%0d.done_strb", n),
          {u_if.vmem_done_o, u_if.vmem_busy_o, u_if.vram_ren_o, u_if.vram_wen_o}, '0);
    end
    chk("abort.dout", u_if.vmem_dout_o, '0);
    run_txn(vt[1], 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/v_mem_access_mb.md
V_MEM_ACCESS_MB -- requirements
Module: v_mem_access_mb

Interface
REQ-001 SHALL have parameter VMEM_DW, default 256: vector-side data width in bits.
REQ-002 SHALL have parameter VMEM_AW, default 32: vector-side byte address width.
REQ-003 SHALL have parameter VRAM_DW, default 64: RAM-side beat width in bits; BEATS = VMEM_DW/VRAM_DW SHALL be a power of two >= 1.
REQ-004 SHALL have parameter VRAM_AW, default 32: RAM-side byte address width.
REQ-005 SHALL have parameter VRAM_RD_LAT, default 1: RAM read latency in cycles, range 1..4.
REQ-006 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port vmem_ren_i, input, 1: vector load request.
REQ-009 SHALL have port vmem_wen_i, input, 1: vector store request.
REQ-010 SHALL have port vmem_addr_i, input, VMEM_AW: base byte address.
REQ-011 SHALL have port vmem_din_i, input, VMEM_DW: store data.
REQ-012 SHALL have port vmem_bmask_i, input, VMEM_DW/8: store byte enables, bit i covers din byte i.
REQ-013 SHALL have port vmem_dout_o, output, VMEM_DW: assembled load data.
REQ-014 SHALL have port vmem_busy_o, output, 1: transfer in progress, new request not accepted.
REQ-015 SHALL have port vmem_done_o, output, 1: one-cycle completion pulse.
REQ-016 SHALL have ports vram_ren_o, output, 1 and vram_wen_o, output, 1: per-beat RAM read and write strobes.
REQ-017 SHALL have port vram_addr_o, output, VRAM_AW: beat byte address.
REQ-018 SHALL have port vram_mask_o, output, VRAM_DW: per-bit write mask, expanded from byte enables.
REQ-019 SHALL have port vram_din_o, output, VRAM_DW: beat write data.
REQ-020 SHALL have port vram_dout_i, input, VRAM_DW: RAM read data.

Function
REQ-021 SHALL implement FSM states IDLE, WRITE, READ, DRAIN, DONE.
REQ-022 IDLE: request sampled when ren or wen is high; SHALL latch addr, din and bmask; wen high -> WRITE, else ren high -> READ; wen has priority if both are high.
REQ-023 Let C = acceptance cycle; beat k (0..BEATS-1) SHALL be driven in cycle C+1+k, one beat per cycle, with no gaps.
REQ-024 Beat address SHALL be base + k*(VRAM_DW/8), truncated modulo 2^VRAM_AW; wrap is silent.
REQ-025 Beat k SHALL carry din bits [k*VRAM_DW +: VRAM_DW] and mask bits expanded from bmask bytes [k*VRAM_DW/8 +: VRAM_DW/8].
REQ-026 A write beat with an all-zero byte mask SHALL still occupy its cycle, with vram_wen_o=0.
REQ-027 WRITE -> DONE after the last beat; done_o SHALL be high in cycle C+1+BEATS.
REQ-028 READ -> DRAIN after the last beat issues; data for beat k SHALL be captured from vram_dout_i in cycle C+1+k+VRAM_RD_LAT into slice k, tracked by a VRAM_RD_LAT-deep valid/index pipeline.
REQ-029 DRAIN -> DONE once the last beat is captured; for reads, done_o SHALL be high and vmem_dout_o updated in cycle C+2+BEATS+VRAM_RD_LAT-1 (one cycle after the last capture).
REQ-030 vmem_dout_o SHALL change only when a complete read finishes and SHALL hold between reads; writes SHALL NOT alter it.
REQ-031 busy_o SHALL be high from C+1 until the cycle before DONE; DONE SHALL behave as IDLE for acceptance, allowing back-to-back requests.
REQ-032 Requests arriving while busy_o=1 SHALL be ignored, not queued.
REQ-033 vram_ren_o, vram_wen_o and vram_mask_o SHALL be 0 in cycles with no beat; vram_addr_o and vram_din_o SHALL then hold their last values.

Reset
REQ-034 rst high SHALL immediately force: state IDLE, busy_o=0, done_o=0, vram_ren_o=0, vram_wen_o=0, vram_mask_o=0, vram_addr_o=0, vram_din_o=0, vmem_dout_o=0, and read pipeline cleared.
REQ-035 Reset mid-transfer SHALL abort it with no done_o pulse and no further RAM strobes; RAM data returning after reset SHALL be discarded.

Verification (VMEM_DW=256, VRAM_DW=64, LAT=1, BEATS=4)
REQ-036 Store at 0x100 with full mask: expect wen high for 4 cycles, addr 0x100/108/110/118, mask all-ones, done_o high in cycle C+5.
REQ-037 Load at 0x200 from RAM with word k=k+1: expect dout_o={4,3,2,1} per 64-bit slice, done_o in cycle C+6, busy_o low in that cycle.
REQ-038 Store with bmask=0x0000_FF00: expect beat 1 mask=all-ones, beats 0/2/3 with wen=0, and total duration still 4 beats.
REQ-039 ren and wen high together: expect a write; a request while busy is dropped; a back-to-back request in the DONE cycle is accepted.
REQ-040 Base 0xFFFF_FFF0: expect beat addrs FFFF_FFF0, FFFF_FFF8, 0000_0000, 0000_0008.
REQ-041 rst asserted during beat 2 of a load: expect outputs 0 immediately, no done_o, dout_o=0; a subsequent load completes normally.
